// File: rtl/usb4_tx_pkg.sv
// Shared types and defaults for the USB4 logical-layer transmit scheduler.
package usb4_tx_pkg;

    typedef enum logic [0:0] {
        TX_IDLE   = 1'b0,
        TX_ACTIVE = 1'b1
    } tx_state_e;

    localparam logic [7:0] DEFAULT_IDLE_WORD = 8'h00;

endpackage

// File: rtl/serializer_tx_scheduler_rr_arbiter.sv
// Round-robin arbiter over the non-priority requesters; the search starts at
// the requester after the last one granted and only moves on an advance strobe.
module rr_arbiter
    import usb4_tx_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(N - 1);
    localparam logic [PW-1:0] IDX_ONE  = PW'(1);

    logic [PW-1:0] next_r;
    logic [PW-1:0] win_idx_s;
    logic [PW-1:0] idx_s;
    logic          hit_s;
    logic          found_s;
    logic [N-1:0]  grant_s;

    // First requesting index at or after the search pointer, wrapping once.
    always_comb begin
        grant_s   = '0;
        win_idx_s = next_r;
        found_s   = 1'b0;
        idx_s     = '0;
        hit_s     = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx_s          = PW'((int'(next_r) + i) % N);
            hit_s          = !found_s && req[idx_s];
            grant_s[idx_s] = hit_s;
            win_idx_s      = hit_s ? idx_s : win_idx_s;
            found_s        = found_s | hit_s;
        end
    end

    // Search pointer: moves just past the winner when the grant is consumed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            next_r <= '0;
        end else if (advance) begin
            next_r <= (win_idx_s == LAST_IDX) ? '0 : win_idx_s + IDX_ONE;
        end
    end

    assign grant = grant_s;

endmodule

// File: rtl/serializer_tx_scheduler.sv
// Shares the transmit bus_serializer between word sources: mirrors its reload
// counter, arbitrates at each fetch point, pads gaps with idle words.
module serializer_tx_scheduler
    import usb4_tx_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    NUM_REQ    = 3,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = DATA_WIDTH'(DEFAULT_IDLE_WORD),
    parameter int                    IDLE_LIMIT = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          stop,
    output logic                          ser_enable,
    output logic [DATA_WIDTH-1:0]         ser_data,
    output logic                          busy,
    output logic                          word_start
);

    localparam int SW = $clog2(DATA_WIDTH);
    localparam int IW = $clog2(IDLE_LIMIT + 2);
    localparam logic [SW-1:0] SLOT_LOAD  = SW'(DATA_WIDTH - 1);
    localparam logic [SW-1:0] SLOT_FETCH = SW'(1);
    localparam logic [IW-1:0] IDLE_MAX   = IW'(IDLE_LIMIT);
    localparam logic [IW-1:0] IDLE_ONE   = IW'(1);
    localparam logic [0:0]    ST_IDLE    = TX_IDLE;
    localparam logic [0:0]    ST_ACTIVE  = TX_ACTIVE;

    logic [0:0]            state_r;
    logic [SW-1:0]         slot_cnt_r;
    logic [IW-1:0]         idle_cnt_r;
    logic                  ser_enable_r;
    logic [DATA_WIDTH-1:0] ser_data_r;

    logic                  fetch_s;
    logic                  grant_s;
    logic                  rr_adv_s;
    logic [NUM_REQ-2:0]    rr_grant_s;
    logic [NUM_REQ-1:0]    ready_s;
    logic [DATA_WIDTH-1:0] win_data_s;

    rr_arbiter #(
        .N(NUM_REQ - 1)
    ) u_rr_arbiter (
        .clk    (clk),
        .rst    (rst),
        .req    (req_valid[NUM_REQ-1:1]),
        .advance(rr_adv_s),
        .grant  (rr_grant_s)
    );

    // Fetch point detection and the one-hot grant; requester 0 overrides the ring.
    always_comb begin
        fetch_s    = 1'b0;
        grant_s    = 1'b0;
        ready_s    = '0;
        rr_adv_s   = 1'b0;
        win_data_s = '0;
        if (!rst) begin
            fetch_s = 1'b0;
        end else if (state_r == ST_IDLE) begin
            fetch_s = (|req_valid) && !stop;
        end else begin
            fetch_s = (slot_cnt_r == SLOT_FETCH);
        end
        grant_s = fetch_s && !stop && (|req_valid);
        if (!grant_s) begin
            ready_s = '0;
        end else if (req_valid[0]) begin
            ready_s = {{(NUM_REQ-1){1'b0}}, 1'b1};
        end else begin
            ready_s  = {rr_grant_s, 1'b0};
            rr_adv_s = 1'b1;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            win_data_s = win_data_s
                       | (req_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{ready_s[i]}});
        end
    end

    // Scheduler state, serializer-mirroring slot counter and output word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            slot_cnt_r   <= '0;
            idle_cnt_r   <= '0;
            ser_enable_r <= 1'b0;
            ser_data_r   <= '0;
        end else if (fetch_s) begin
            slot_cnt_r <= '0;
            if (stop) begin
                ser_enable_r <= 1'b0;
                state_r      <= ST_IDLE;
            end else if (grant_s) begin
                ser_data_r   <= win_data_s;
                ser_enable_r <= 1'b1;
                state_r      <= ST_ACTIVE;
                idle_cnt_r   <= '0;
            end else if (idle_cnt_r < IDLE_MAX) begin
                ser_data_r <= IDLE_WORD;
                idle_cnt_r <= idle_cnt_r + IDLE_ONE;
            end else begin
                ser_enable_r <= 1'b0;
                state_r      <= ST_IDLE;
            end
        end else if (ser_enable_r) begin
            // Same reload rule as the serializer: 0 is the load edge.
            slot_cnt_r <= (slot_cnt_r == '0) ? SLOT_LOAD : slot_cnt_r - SLOT_FETCH;
        end else begin
            slot_cnt_r <= '0;
        end
    end

    assign req_ready  = ready_s;
    assign ser_enable = ser_enable_r;
    assign ser_data   = ser_data_r;
    assign busy       = ser_enable_r;
    assign word_start = ser_enable_r && (slot_cnt_r == '0);

endmodule

// File: doc/serializer_tx_scheduler.md
# serializer_tx_scheduler

Sequences and shares the transmit `bus_serializer` (DATA_WIDTH-bit parallel in, 1-bit serial out) between several word sources in the USB4 logical-layer transmit path. It mirrors the serializer's internal reload counter so that each new word is presented exactly on the serializer's load edge. It arbitrates among requesters, with requester 0 at strict priority and the others round-robin. During gaps it keeps the serializer running with idle words and shuts it down after a programmable idle run.

## Interface
- DATA_WIDTH, 8: serializer word width; must be ≥2.
- NUM_REQ, 3: number of requesters; must be ≥2. Requester 0 is the priority source (ordered sets).
- IDLE_WORD, 8'h00: word sent when no requester is valid at a fetch point.
- IDLE_LIMIT, 4: consecutive idle words sent before disabling the serializer; 0 disables immediately.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester word available.
- req_data  in  NUM_REQ*DATA_WIDTH  flattened words; requester i uses slice [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  one-hot grant pulse; a word transfers when valid&ready.
- stop  in  1  request orderly shutdown after the current word.
- ser_enable  out  1  drives serializer `enable`.
- ser_data  out  DATA_WIDTH  drives serializer `parallel_data`.
- busy  out  1  high whenever ser_enable is high.
- word_start  out  1  one-cycle pulse on each cycle in which the serializer loads ser_data.

## Operation
- States: IDLE, ACTIVE.
- slot_cnt, width $clog2(DATA_WIDTH), mirrors the serializer counter:
  - 0 means load edge.
  - After a load it becomes DATA_WIDTH-1, then decrements to 0.
- Fetch cycle:
  - In IDLE: any req_valid high (and stop low).
  - In ACTIVE: slot_cnt==1.
- At a fetch cycle:
  - Winner: requester 0 if valid; otherwise round-robin among 1..NUM_REQ-1, starting after the last granted.
  - req_ready is high for the winner only, combinationally, in that cycle. Outside fetch cycles req_ready is 0.
  - At the edge: ser_data ← winner data; slot_cnt ← 0; round-robin pointer updates only on grants to requesters 1..NUM_REQ-1; idle_cnt ← 0.
- ACTIVE fetch with no valid requester and stop low:
  - If idle_cnt < IDLE_LIMIT: ser_data ← IDLE_WORD and idle_cnt increments.
  - Otherwise: ser_enable ← 0 and go to IDLE.
- ACTIVE fetch with stop high: no grant; ser_enable ← 0; go to IDLE. stop overrides pending requests.
- IDLE with stop high: no grants.
- Dropping ser_enable at the fetch edge keeps the last bit of the current word on serial_out for its full cycle before the serializer clears.
- Requesters hold req_data stable while req_valid is high and ready is low.

## Timing
- Reset (rst low at an edge): state=IDLE, slot_cnt=0, idle_cnt=0, rr pointer → requester 1, ser_enable=0, ser_data=0, busy=0, word_start=0. req_ready is 0 while rst is low.
- Reset mid-word aborts at once. The serializer is cleared by its own reset, or by enable low next cycle.
- First word latency:
  - Cycle T: req_valid in IDLE → req_ready at T.
  - T+1: ser_enable=1 and ser_data valid; the serializer loads at the end of T+1 (word_start=1 at T+1).
  - T+2: first bit (MSB) on serial_out.
- Back-to-back words: one load every DATA_WIDTH cycles, no bubbles. word_start is periodic with period DATA_WIDTH while ACTIVE.
- word_start = ser_enable && slot_cnt==0.
- IDLE→ACTIVE restart is allowed in the cycle immediately after ser_enable falls.

## Structure
- Package `usb4_tx_pkg`: state enum; default IDLE_WORD constant.
- Sub-module `rr_arbiter` (NUM_REQ-1 inputs, one-hot grant, pointer update on an advance strobe). Priority override for requester 0 stays in the top level.

## Test plan
- Single word: req_valid[1]=1 with 8'hA5 in IDLE → req_ready[1] at T; ser_data=8'hA5 and word_start at T+1; serializer emits 1,0,1,0,0,1,0,1 over T+2..T+9.
- Round-robin: req 1 and req 2 continuously valid → grants alternate 1,2,1,2; word_start every 8 cycles, no gaps.
- Priority: req 0 becomes valid while req 1 and req 2 are pending → next fetch grants req 0; the round-robin pointer is unchanged.
- Idle timeout: a single word followed by no requests, IDLE_LIMIT=4 → four IDLE_WORD loads, then ser_enable falls on the 5th fetch edge; busy=0.
- Stop: stop asserted mid-word while req 1 is valid → current word completes all 8 bits; no grant; ser_enable=0 after the fetch edge.
- Reset mid-word: rst low at slot_cnt=4 → all outputs take reset values next edge; after release with a request pending, restart with the first-word latency above.
